uci_host_driver: RTL and testbench

GUI/host-side counterpart of the board's UCI engine interface. It holds the game's move history and, on request, serialises `position startpos [moves ...]\n` followed by `go\n` onto a byte stream toward the engine. It then parses the engine's reply lines, decodes `bestmove` into a `move_t`, and appends that move to the history. It is used as a hardware self-play/test driver and as the front end for an on-chip opponent.

---
 rtl/uci_host_driver.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_uci_host_driver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uci_host_driver.sv
// Host-side UCI driver: keeps the move history, streams "position startpos [moves ...]\ngo\n"
// to the engine and decodes its "bestmove" reply. Move word = {src_col, src_row, dst_col, dst_row, special[3:0]}.
//
// state        | meaning
// S_IDLE       | accepting moves, clear and go requests
// S_SEND_POS   | emitting "position startpos"
// S_SEND_HDR   | emitting " moves"
// S_SEND_MOVE  | emitting " <from><to>[promo]" for each stored ply, oldest first
// S_SEND_NL    | emitting the line feed that ends the position command
// S_SEND_GO    | emitting "go\n"
// S_WAIT_REPLY | waiting for a bestmove line from the engine
module uci_host_driver #(
    parameter int MAX_MOVES = 64
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [15:0]                    move_in,
    input  logic                           move_in_valid,
    output logic                           move_in_ready,
    input  logic                           clear_in,
    input  logic                           go_in_valid,
    output logic                           go_in_ready,
    output logic [7:0]                     char_out,
    output logic                           char_out_valid,
    input  logic                           char_out_ready,
    input  logic [7:0]                     char_in,
    input  logic                           char_in_valid,
    output logic                           char_in_ready,
    output logic [15:0]                    best_move_out,
    output logic                           best_move_out_valid,
    output logic [$clog2(MAX_MOVES+1)-1:0] history_count,
    output logic                           overflow,
    output logic                           busy
);

    localparam int CNT_W = $clog2(MAX_MOVES + 1);
    localparam int IDX_W = (MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1;

    localparam logic [3:0] SP_NONE    = 4'd0;
    localparam logic [3:0] SP_KNIGHT  = 4'd1;
    localparam logic [3:0] SP_BISHOP  = 4'd2;
    localparam logic [3:0] SP_ROOK    = 4'd3;
    localparam logic [3:0] SP_QUEEN   = 4'd4;
    localparam logic [3:0] SP_UNKNOWN = 4'hF;

    localparam logic [7:0] LF = 8'h0A;

    // Fixed text: [0..16] "position startpos", [17..22] " moves", [23..25] "go\n"
    localparam int            TXT_LEN = 26;
    localparam logic [207:0]  TXT     = "position startpos movesgo\n";
    localparam logic [71:0]   PFX     = "bestmove ";

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_POS, S_SEND_HDR, S_SEND_MOVE, S_SEND_NL, S_SEND_GO, S_WAIT_REPLY
    } state_t;

    typedef enum logic [1:0] {P_MATCH, P_CAPTURE, P_SKIP} p_mode_t;

    state_t             state, state_nx;
    logic [4:0]         chr_idx, chr_idx_nx;
    logic [IDX_W-1:0]   ply_idx, ply_nx;

    logic [15:0]        hist [MAX_MOVES];
    logic               hist_we;
    logic [15:0]        hist_wd;

    p_mode_t            p_mode;
    logic [3:0]         pfx_idx;
    logic [7:0]         cap_buf [5];
    logic [2:0]         cap_len;
    logic               cap_long;

    logic               tx_free, load, has_room, reply_take, parse_done, mv_promo, dec_shape_ok;
    logic [7:0]         load_byte, txt_byte, mv_byte, promo_chr, pfx_byte;
    logic [15:0]        cur_mv, dec_move;
    logic [3:0]         dec_special;

    function automatic logic is_file(input logic [7:0] c);
        return (c >= 8'h61) && (c <= 8'h68);
    endfunction

    function automatic logic is_rank(input logic [7:0] c);
        return (c >= 8'h31) && (c <= 8'h38);
    endfunction

    // 'a' and '1' both have 3'b001 in their low bits, so (c - base) mod 8 is c[2:0] - 1
    function automatic logic [2:0] coord(input logic [2:0] c);
        return c - 3'd1;
    endfunction

    assign busy          = (state != S_IDLE);
    assign go_in_ready   = (state == S_IDLE);
    assign has_room      = (history_count < CNT_W'(MAX_MOVES));
    assign move_in_ready = (state == S_IDLE) && has_room;
    assign char_in_ready = 1'b1;
    assign tx_free       = !char_out_valid || char_out_ready;
    assign txt_byte      = 8'(TXT >> (8 * (TXT_LEN - 1 - int'(chr_idx))));
    assign pfx_byte      = 8'(PFX >> (8 * (8 - int'(pfx_idx))));
    assign parse_done    = char_in_valid && (p_mode == P_CAPTURE) &&
                           ((char_in == 8'h20) || (char_in == LF));
    assign reply_take    = parse_done && (state == S_WAIT_REPLY);

    always_comb begin
        cur_mv    = hist[ply_idx];
        mv_promo  = 1'b1;
        promo_chr = 8'h71;
        case (cur_mv[3:0])
            SP_KNIGHT: promo_chr = 8'h6E;
            SP_BISHOP: promo_chr = 8'h62;
            SP_ROOK:   promo_chr = 8'h72;
            SP_QUEEN:  promo_chr = 8'h71;
            default:   mv_promo  = 1'b0;
        endcase
        case (chr_idx)
            5'd0:    mv_byte = 8'h20;
            5'd1:    mv_byte = 8'h61 + {5'd0, cur_mv[15:13]};
            5'd2:    mv_byte = 8'h31 + {5'd0, cur_mv[12:10]};
            5'd3:    mv_byte = 8'h61 + {5'd0, cur_mv[9:7]};
            5'd4:    mv_byte = 8'h31 + {5'd0, cur_mv[6:4]};
            default: mv_byte = promo_chr;
        endcase
    end

    always_comb begin
        dec_shape_ok = is_file(cap_buf[0]) && is_rank(cap_buf[1]) &&
                       is_file(cap_buf[2]) && is_rank(cap_buf[3]);
        dec_special  = SP_UNKNOWN;
        if (!cap_long && dec_shape_ok) begin
            if (cap_len == 3'd4) begin
                dec_special = SP_NONE;
            end else if (cap_len == 3'd5) begin
                case (cap_buf[4])
                    8'h6E:   dec_special = SP_KNIGHT;
                    8'h62:   dec_special = SP_BISHOP;
                    8'h72:   dec_special = SP_ROOK;
                    8'h71:   dec_special = SP_QUEEN;
                    default: dec_special = SP_UNKNOWN;
                endcase
            end
        end
        dec_move = {coord(cap_buf[0][2:0]), coord(cap_buf[1][2:0]),
                    coord(cap_buf[2][2:0]), coord(cap_buf[3][2:0]), dec_special};
    end

    always_comb begin
        state_nx   = state;
        chr_idx_nx = chr_idx;
        ply_nx     = ply_idx;
        load       = 1'b0;
        load_byte  = txt_byte;
        case (state)
            S_IDLE: begin
                if (!clear_in && go_in_valid) begin
                    state_nx = S_SEND_POS;
                    // a stalled trailing byte must drain before 'p' can be loaded
                    if (tx_free) begin
                        load       = 1'b1;
                        chr_idx_nx = 5'd1;
                    end
                end
            end
            S_SEND_POS: begin
                if (tx_free) begin
                    load = 1'b1;
                    if (chr_idx == 5'd16) begin
                        state_nx   = (history_count == '0) ? S_SEND_NL : S_SEND_HDR;
                        chr_idx_nx = (history_count == '0) ? 5'd23 : 5'd17;
                    end else begin
                        chr_idx_nx = chr_idx + 5'd1;
                    end
                end
            end
            S_SEND_HDR: begin
                if (tx_free) begin
                    load = 1'b1;
                    if (chr_idx == 5'd22) begin
                        state_nx   = S_SEND_MOVE;
                        chr_idx_nx = 5'd0;
                        ply_nx     = '0;
                    end else begin
                        chr_idx_nx = chr_idx + 5'd1;
                    end
                end
            end
            S_SEND_MOVE: begin
                load_byte = mv_byte;
                if (tx_free) begin
                    load = 1'b1;
                    if ((chr_idx == 5'd5) || ((chr_idx == 5'd4) && !mv_promo)) begin
                        chr_idx_nx = 5'd0;
                        if (CNT_W'(ply_idx) + CNT_W'(1) == history_count) begin
                            state_nx   = S_SEND_NL;
                            chr_idx_nx = 5'd23;
                        end else begin
                            ply_nx = ply_idx + IDX_W'(1);
                        end
                    end else begin
                        chr_idx_nx = chr_idx + 5'd1;
                    end
                end
            end
            S_SEND_NL: begin
                load_byte = LF;
                if (tx_free) begin
                    load       = 1'b1;
                    state_nx   = S_SEND_GO;
                    chr_idx_nx = 5'd23;
                end
            end
            S_SEND_GO: begin
                if (tx_free) begin
                    load = 1'b1;
                    if (chr_idx == 5'd25) begin
                        state_nx   = S_WAIT_REPLY;
                        chr_idx_nx = 5'd0;
                    end else begin
                        chr_idx_nx = chr_idx + 5'd1;
                    end
                end
            end
            S_WAIT_REPLY: begin
                if (parse_done) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state   <= S_IDLE;
            chr_idx <= '0;
            ply_idx <= '0;
        end else begin
            state   <= state_nx;
            chr_idx <= chr_idx_nx;
            ply_idx <= ply_nx;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            char_out       <= '0;
            char_out_valid <= 1'b0;
        end else if (load) begin
            char_out       <= load_byte;
            char_out_valid <= 1'b1;
        end else if (char_out_ready) begin
            char_out_valid <= 1'b0;
        end
    end

    always_comb begin
        hist_we = 1'b0;
        hist_wd = move_in;
        if ((state == S_IDLE) && !clear_in && !go_in_valid && move_in_valid && has_room) begin
            hist_we = 1'b1;
        end else if (reply_take && (dec_special != SP_UNKNOWN) && has_room) begin
            hist_we = 1'b1;
            hist_wd = dec_move;
        end
    end

    always_ff @(posedge clk_in) begin
        if (hist_we) hist[history_count[IDX_W-1:0]] <= hist_wd;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            history_count       <= '0;
            overflow            <= 1'b0;
            best_move_out       <= '0;
            best_move_out_valid <= 1'b0;
        end else begin
            best_move_out_valid <= reply_take;
            if (reply_take) best_move_out <= dec_move;
            if ((state == S_IDLE) && clear_in) begin
                history_count <= '0;
            end else if (hist_we) begin
                history_count <= history_count + CNT_W'(1);
            end
            if (reply_take && (dec_special != SP_UNKNOWN) && !has_room) overflow <= 1'b1;
        end
    end

    // Line parser runs in every state; only WAIT_REPLY consumes its result
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            p_mode   <= P_MATCH;
            pfx_idx  <= '0;
            cap_len  <= '0;
            cap_long <= 1'b0;
            for (int i = 0; i < 5; i++) cap_buf[i] <= '0;
        end else if (char_in_valid) begin
            case (p_mode)
                P_MATCH: begin
                    if (char_in == LF) begin
                        pfx_idx <= '0;
                    end else if (char_in == pfx_byte) begin
                        if (pfx_idx == 4'd8) begin
                            p_mode   <= P_CAPTURE;
                            pfx_idx  <= '0;
                            cap_len  <= '0;
                            cap_long <= 1'b0;
                        end else begin
                            pfx_idx <= pfx_idx + 4'd1;
                        end
                    end else begin
                        p_mode <= P_SKIP;
                    end
                end
                P_CAPTURE: begin
                    if (parse_done) begin
                        p_mode  <= (char_in == LF) ? P_MATCH : P_SKIP;
                        pfx_idx <= '0;
                    end else if (cap_len == 3'd5) begin
                        cap_long <= 1'b1;
                    end else begin
                        cap_buf[cap_len] <= char_in;
                        cap_len          <= cap_len + 3'd1;
                    end
                end
                P_SKIP: begin
                    if (char_in == LF) begin
                        p_mode  <= P_MATCH;
                        pfx_idx <= '0;
                    end
                end
                default: p_mode <= P_MATCH;
            endcase
        end
    end

endmodule

// File: tb/tb_uci_host_driver.sv
// Directed bench for uci_host_driver: a MAX_MOVES=64 instance and a MAX_MOVES=2 instance share all inputs.
module tb_uci_host_driver;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] move_in;
    logic        move_in_valid, clear_in, go_in_valid, char_out_ready, char_in_valid;
    logic [7:0]  char_in;

    logic        a_move_rdy, a_go_rdy, a_cov, a_cir, a_bmv, a_ovf, a_busy;
    logic [7:0]  a_co;
    logic [15:0] a_bm;
    logic [6:0]  a_cnt;
    logic        b_move_rdy, b_go_rdy, b_cov, b_cir, b_bmv, b_ovf, b_busy;
    logic [7:0]  b_co;
    logic [15:0] b_bm;
    logic [1:0]  b_cnt;

    int checks = 0;
    int errors = 0;
    int a_pulses = 0;
    int b_pulses = 0;
    logic [15:0] a_last = '0;
    logic [15:0] model[$];

    always #5 clk_in = ~clk_in;

    uci_host_driver #(.MAX_MOVES(64)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .move_in(move_in), .move_in_valid(move_in_valid), .move_in_ready(a_move_rdy),
        .clear_in(clear_in), .go_in_valid(go_in_valid), .go_in_ready(a_go_rdy),
        .char_out(a_co), .char_out_valid(a_cov), .char_out_ready(char_out_ready),
        .char_in(char_in), .char_in_valid(char_in_valid), .char_in_ready(a_cir),
        .best_move_out(a_bm), .best_move_out_valid(a_bmv),
        .history_count(a_cnt), .overflow(a_ovf), .busy(a_busy)
    );

    uci_host_driver #(.MAX_MOVES(2)) dut2 (
        .clk_in(clk_in), .rst_in(rst_in),
        .move_in(move_in), .move_in_valid(move_in_valid), .move_in_ready(b_move_rdy),
        .clear_in(clear_in), .go_in_valid(go_in_valid), .go_in_ready(b_go_rdy),
        .char_out(b_co), .char_out_valid(b_cov), .char_out_ready(char_out_ready),
        .char_in(char_in), .char_in_valid(char_in_valid), .char_in_ready(b_cir),
        .best_move_out(b_bm), .best_move_out_valid(b_bmv),
        .history_count(b_cnt), .overflow(b_ovf), .busy(b_busy)
    );

    always @(negedge clk_in) begin
        if (a_bmv) begin
            a_pulses++;
            a_last = a_bm;
        end
        if (b_bmv) b_pulses++;
    end

    typedef struct packed {
        logic [511:0] text;
        logic [15:0]  exp_move;
        logic         exp_app;
        logic         rnd;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    function automatic logic [15:0] mv(int sc, int sr, int dc, int dr, int sp);
        return {3'(sc), 3'(sr), 3'(dc), 3'(dr), 4'(sp)};
    endfunction

    function automatic vec_t mk(logic [511:0] t, logic [15:0] m, logic app, logic rnd);
        vec_t v;
        v.text = t; v.exp_move = m; v.exp_app = app; v.rnd = rnd;
        return v;
    endfunction

    function automatic string build_tx();
        string s = "position startpos";
        if (model.size() > 0) s = {s, " moves"};
        foreach (model[k]) begin
            logic [15:0] m = model[k];
            s = $sformatf("%s %c%c%c%c", s, 8'h61 + 8'(m[15:13]), 8'h31 + 8'(m[12:10]),
                          8'h61 + 8'(m[9:7]), 8'h31 + 8'(m[6:4]));
            case (m[3:0])
                4'd1: s = {s, "n"};
                4'd2: s = {s, "b"};
                4'd3: s = {s, "r"};
                4'd4: s = {s, "q"};
                default: ;
            endcase
        end
        return {s, "\ngo\n"};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        move_in = '0; move_in_valid = 1'b0; clear_in = 1'b0; go_in_valid = 1'b0;
        char_out_ready = 1'b0; char_in = '0; char_in_valid = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic push(input logic [15:0] m);
        @(negedge clk_in);
        move_in = m; move_in_valid = 1'b1;
        @(negedge clk_in);
        move_in_valid = 1'b0;
    endtask

    task automatic send_text(input logic [511:0] t);
        for (int i = 63; i >= 0; i--) begin
            if (t[i*8 +: 8] != 8'h00) begin
                @(negedge clk_in);
                char_in = t[i*8 +: 8];
                char_in_valid = 1'b1;
            end
        end
        @(negedge clk_in);
        char_in_valid = 1'b0;
        @(negedge clk_in);
    endtask

    // Pulses go (optionally with a competing move_in), then collects the byte stream of dut.
    task automatic run_go(input string exp, input bit rnd, input string name, input bit with_move);
        logic [7:0] got[$];
        logic [7:0] prev = '0;
        bit   stall_prev = 1'b0;
        bit   rdy;
        int   stall_err = 0, extra = 0, mism = 0, first_bad = -1, cyc = 0;
        logic [6:0] cnt0 = a_cnt;
        @(negedge clk_in);
        go_in_valid = 1'b1;
        if (with_move) begin
            move_in = mv(0, 1, 0, 3, 0);
            move_in_valid = 1'b1;
        end
        @(negedge clk_in);
        go_in_valid = 1'b0;
        move_in_valid = 1'b0;
        check({name, " busy after go"}, 32'(a_busy), 32'd1);
        check({name, " first byte"}, {23'd0, a_cov, a_co}, 32'h170);
        while (got.size() < exp.len() && cyc < 3000) begin
            if (stall_prev && (a_cov !== 1'b1 || a_co !== prev)) stall_err++;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            char_out_ready = rdy;
            if (a_cov && rdy) got.push_back(a_co);
            stall_prev = a_cov && !rdy;
            prev = a_co;
            @(negedge clk_in);
            cyc++;
        end
        char_out_ready = 1'b1;
        repeat (4) begin
            if (a_cov) extra++;
            @(negedge clk_in);
        end
        for (int i = 0; i < got.size() && i < exp.len(); i++) begin
            if (got[i] !== exp.getc(i)) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        check({name, " byte count"}, 32'(got.size()), 32'(exp.len()));
        check({name, " byte mismatches"}, 32'(mism), 32'd0);
        if (mism != 0) $display("  first differing byte index %0d", first_bad);
        check({name, " stall stability"}, 32'(stall_err), 32'd0);
        check({name, " extra bytes"}, 32'(extra), 32'd0);
        check({name, " waiting reply"}, {30'd0, a_busy, a_go_rdy}, 32'h2);
        check({name, " count held"}, 32'(a_cnt), 32'(cnt0));
    endtask

    initial begin
        int p0;
        vecs[0] = mk("info depth 1 score cp 20\nbestmove g1f3 ponder b8c6\n", mv(6, 0, 5, 2, 0), 1'b1, 1'b0);
        vecs[1] = mk("bestmove a7a8q\n",                 mv(0, 6, 0, 7, 4),  1'b1, 1'b1);
        vecs[2] = mk("bestmove z9a1\n",                  mv(1, 0, 0, 0, 15), 1'b0, 1'b0);
        vecs[3] = mk("id name x\nreadyok\n\nbestmove b1c3\n", mv(1, 0, 2, 2, 0), 1'b1, 1'b1);
        vecs[4] = mk("bestmove h7h8n ponder x\n",        mv(7, 6, 7, 7, 1),  1'b1, 1'b0);
        vecs[5] = mk("bestmove e2e4e5\n",                mv(4, 1, 4, 3, 15), 1'b0, 1'b1);
        vecs[6] = mk("bestmove e7e5x\n",                 mv(4, 6, 4, 4, 15), 1'b0, 1'b0);
        vecs[7] = mk("bestmove d7d8r\n",                 mv(3, 6, 3, 7, 3),  1'b1, 1'b1);
        vecs[8] = mk("bestmove c2c1b\n",                 mv(2, 1, 2, 0, 2),  1'b1, 1'b0);

        do_reset();
        check("reset char_out_valid", 32'(a_cov), 32'd0);
        check("reset best valid", 32'(a_bmv), 32'd0);
        check("reset count/ovf/busy", {23'd0, a_cnt, a_ovf, a_busy}, 32'd0);
        check("reset readies", {29'd0, a_move_rdy, a_go_rdy, a_cir}, 32'h7);

        run_go("position startpos\ngo\n", 1'b0, "empty", 1'b0);

        do_reset();
        push(mv(4, 1, 4, 3, 0));
        push(mv(4, 6, 4, 4, 0));
        model.push_back(mv(4, 1, 4, 3, 0));
        model.push_back(mv(4, 6, 4, 4, 0));
        check("two pushes count", 32'(a_cnt), 32'd2);
        run_go("position startpos moves e2e4 e7e5\ngo\n", 1'b0, "two moves", 1'b0);

        for (int i = 0; i < NV; i++) begin
            if (i > 0) run_go(build_tx(), vecs[i].rnd, $sformatf("go%0d", i), 1'b0);
            p0 = a_pulses;
            send_text(vecs[i].text);
            if (vecs[i].exp_app) model.push_back(vecs[i].exp_move);
            check($sformatf("reply%0d pulses", i), 32'(a_pulses - p0), 32'd1);
            check($sformatf("reply%0d move", i), 32'(a_last), 32'(vecs[i].exp_move));
            check($sformatf("reply%0d count", i), 32'(a_cnt), 32'(model.size()));
            check($sformatf("reply%0d idle", i), 32'(a_busy), 32'd0);
        end
        check("no overflow in deep history", 32'(a_ovf), 32'd0);

        p0 = a_pulses;
        send_text("bestmove e2e4\n");
        check("idle reply ignored", 32'(a_pulses - p0), 32'd0);
        check("idle reply count", 32'(a_cnt), 32'(model.size()));

        @(negedge clk_in);
        clear_in = 1'b1; go_in_valid = 1'b1; move_in_valid = 1'b1;
        @(negedge clk_in);
        clear_in = 1'b0; go_in_valid = 1'b0; move_in_valid = 1'b0;
        model.delete();
        check("clear wins count", 32'(a_cnt), 32'd0);
        check("clear wins busy", 32'(a_busy), 32'd0);

        run_go("position startpos\ngo\n", 1'b0, "go over move", 1'b1);
        send_text("bestmove e2e4\n");
        check("after clear append", 32'(a_cnt), 32'd1);

        do_reset();
        push(mv(4, 1, 4, 3, 0));
        push(mv(4, 6, 4, 4, 0));
        check("small full count", 32'(b_cnt), 32'd2);
        check("small full ready", {30'd0, b_move_rdy, a_move_rdy}, 32'h1);
        run_go("position startpos moves e2e4 e7e5\ngo\n", 1'b1, "small stream", 1'b0);
        p0 = b_pulses;
        send_text("bestmove g1f3\n");
        check("small pulse", 32'(b_pulses - p0), 32'd1);
        check("small overflow", 32'(b_ovf), 32'd1);
        check("small count held", 32'(b_cnt), 32'd2);
        check("big appended", {24'd0, a_cnt, a_ovf}, {24'd0, 7'd3, 1'b0});

        @(negedge clk_in);
        go_in_valid = 1'b1;
        @(negedge clk_in);
        go_in_valid = 1'b0;
        char_out_ready = 1'b1;
        repeat (25) @(negedge clk_in);
        check("mid move sending", {30'd0, a_busy, a_cov}, 32'h3);
        #2 rst_in = 1'b0;
        #1;
        check("async drop valid", {30'd0, a_cov, b_cov}, 32'd0);
        check("async busy", {30'd0, a_busy, b_busy}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("post reset counts", {24'd0, a_cnt, b_cnt[0]}, 32'd0);
        check("post reset b count/ovf", {29'd0, b_cnt, b_ovf}, 32'd0);
        check("post reset idle", {29'd0, a_go_rdy, a_cov, b_cov}, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
